// File: rtl/serial_adder_ctrl_pkg.sv
// Shared state encodings and defaults for the bit-serial add/subtract controller.
package serial_adder_ctrl_pkg;

  localparam int DEF_WIDTH = 8;

  // 2'd3 is unused and falls back to S_IDLE.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // States in which a new request may be accepted.
  function automatic logic can_accept(input logic [1:0] st);
    return (st == S_IDLE) || (st == S_DONE);
  endfunction

endpackage

// File: rtl/full_adder.sv
// Existing 1-bit full adder cell, shared bit-serially by serial_adder_ctrl.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit add/subtract: one full_adder cell, LSB first, carry FF closes the loop.
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CW    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  // Holds the WIDTH-1 result bits already produced; the current FA bit completes it.
  logic [WIDTH-2:0] sum_sr;
  logic [WIDTH-1:0] sum_next;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_sum;
  logic             fa_carry;

  full_adder u_fa (
    .a     (a_sr[0]),
    .b     (b_sr[0]),
    .c     (carry),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  assign sum_next = {fa_sum, sum_sr};

  assign ready = can_accept(state);
  assign busy  = (state == S_RUN);
  assign done  = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            // Subtract as a + ~b + 1.
            a_sr  <= a;
            b_sr  <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
            cnt   <= '0;
            state <= S_RUN;
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
          sum_sr <= sum_next[WIDTH-1:1];
          carry  <= fa_carry;
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            // carry here is the carry into the MSB.
            ovf   <= carry ^ fa_carry;
            cout  <= fa_carry;
            sum   <= sum_next;
            state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench: cycle-level behavioural model plus directed literal checks and random traffic.
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         ready, busy, done, cout, ovf;
  logic [W-1:0] sum;

  int tests = 0;
  int fails = 0;

  serial_adder_ctrl #(.WIDTH(W), .CW(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Arithmetic result of an operation, from plain integer addition.
  task automatic calc(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic,
                      input logic isub, output logic [W-1:0] s, output logic co, output logic ov);
    logic [W-1:0] bb;
    logic [W:0]   t;
    logic         c0;
    bb = isub ? ~ib : ib;
    c0 = isub ? 1'b1 : ic;
    t  = {1'b0, ia} + {1'b0, bb} + {{W{1'b0}}, c0};
    s  = t[W-1:0];
    co = t[W];
    ov = (ia[W-1] == bb[W-1]) && (s[W-1] != ia[W-1]);
  endtask

  // Model: an accepted op occupies W cycles, then one done cycle.
  int           m_left = 0;
  logic         m_done = 1'b0;
  logic [W-1:0] m_sum = '0, p_sum = '0;
  logic         m_cout = 1'b0, m_ovf = 1'b0, p_cout = 1'b0, p_ovf = 1'b0;
  logic         armed = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_left = 0; m_done = 1'b0; m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_sum = p_sum; m_cout = p_cout; m_ovf = p_ovf; m_done = 1'b1;
        end
      end else if (start) begin
        calc(a, b, cin, sub, p_sum, p_cout, p_ovf);
        m_left = W;
      end
    end
    armed = 1'b1;
  end

  always @(negedge clk) begin
    if (armed) begin
      check("ready", 64'(ready), 64'(m_left == 0));
      check("busy",  64'(busy),  64'(m_left > 0));
      check("done",  64'(done),  64'(m_done));
      check("sum",   64'(sum),   64'(m_sum));
      check("cout",  64'(cout),  64'(m_cout));
      check("ovf",   64'(ovf),   64'(m_ovf));
    end
  end

  // Issues one op (called just after a negedge) and waits for done; cyc = negedges until done.
  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic,
                        input logic isub, output int cyc);
    a = ia; b = ib; cin = ic; sub = isub; start = 1'b1;
    cyc = 0;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) start = 1'b0;
      if (done) break;
      if (cyc > 60) begin
        check("done_timeout", 64'(cyc), 64'(W + 1));
        break;
      end
    end
  endtask

  task automatic pin(input string name, input logic [W-1:0] es, input logic ec, input logic eo, input int cyc);
    check({name, "_lat"},  64'(cyc),  64'(W + 1));
    check({name, "_sum"},  64'(sum),  64'(es));
    check({name, "_cout"}, 64'(cout), 64'(ec));
    check({name, "_ovf"},  64'(ovf),  64'(eo));
  endtask

  initial begin
    int cyc;
    int ndone;
    repeat (2) @(negedge clk);
    check("rst_ready", 64'(ready), 64'd1);
    check("rst_busy",  64'(busy),  64'd0);
    check("rst_sum",   64'(sum),   64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(8'h5A, 8'h3C, 1'b0, 1'b0, cyc); pin("add",   8'h96, 1'b1 == 1'b0, 1'b1, cyc);
    @(negedge clk);
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, cyc); pin("wrap0", 8'h00, 1'b1, 1'b0, cyc);
    run_op(8'hFF, 8'h01, 1'b1, 1'b0, cyc); pin("wrap1", 8'h01, 1'b1, 1'b0, cyc);
    run_op(8'h10, 8'h01, 1'b0, 1'b1, cyc); pin("sub0",  8'h0F, 1'b1, 1'b0, cyc);
    run_op(8'h01, 8'h02, 1'b1, 1'b1, cyc); pin("sub1",  8'hFF, 1'b0, 1'b0, cyc);
    @(negedge clk);

    // Start pulsed while busy must be ignored.
    a = 8'h22; b = 8'h11; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    a = 8'h77; b = 8'h77; sub = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    ndone = 0;
    repeat (W + 4) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        check("ignore_sum", 64'(sum), 64'h33);
      end
    end
    check("ignore_ndone", 64'(ndone), 64'd1);

    // Back-to-back: start in the DONE cycle.
    run_op(8'h05, 8'h03, 1'b0, 1'b0, cyc); pin("b2b_a", 8'h08, 1'b0, 1'b0, cyc);
    run_op(8'h01, 8'h01, 1'b0, 1'b0, cyc); pin("b2b_b", 8'h02, 1'b0, 1'b0, cyc);
    @(negedge clk);

    // Reset mid-run.
    a = 8'h40; b = 8'h40; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_ready", 64'(ready), 64'd1);
    check("mid_rst_busy",  64'(busy),  64'd0);
    check("mid_rst_done",  64'(done),  64'd0);
    check("mid_rst_sum",   64'(sum),   64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(8'h7F, 8'h01, 1'b0, 1'b0, cyc); pin("post_rst", 8'h80, 1'b0, 1'b1, cyc);

    // Random traffic against the model, with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) == 0);
      a     = W'($urandom);
      b     = W'($urandom);
      cin   = 1'($urandom);
      sub   = 1'($urandom);
      rst_n = ($urandom_range(0, 199) != 0);
    end
    @(negedge clk);
    start = 1'b0; rst_n = 1'b1;
    repeat (W + 3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
